set_assoc_read_cache: RTL and testbench

Parametrised, blocking, read-only set-associative cache with its own memory-bus refill engine; the next-generation L1 front end for the pipeline's instruction port (and for read-only data ports). It replaces the fixed 8 KB / 4-way / 64 B-line geometry with parameters. Hits return in one cycle, and misses issue a single line read on the memory bus. It adds per-set round-robin replacement and a whole-cache flush.

---
 rtl/set_assoc_read_cache.sv | 194 +++++++++++++++++++
 tb/tb_set_assoc_read_cache.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_read_cache.sv
// Read-only set-associative cache with a single-outstanding line refill engine.
// Hits answer next cycle; misses fetch one line over the beat bus.
module set_assoc_read_cache #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_BYTES     = 64,
    parameter int WAYS           = 4,
    parameter int SETS           = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG = 13'h1100
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      flush,
    output logic                      busy,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WB_W   = $clog2(DATA_WIDTH / 8);
    localparam int WSEL_W = OFF_W - WB_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / BUS_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WAYS-1:0]       r_valid [SETS];
    logic [WAY_W-1:0]      r_ptr   [SETS];
    logic [TAG_W-1:0]      r_tag   [WAYS][SETS];
    logic [LINE_W-1:0]     r_data  [WAYS][SETS];
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WAY_W-1:0]      r_vict;
    logic [BEAT_W-1:0]     r_beat;
    logic [LINE_W-1:0]     r_fill;
    logic                  r_flush_pend;
    logic                  r_hit_q;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [IDX_W-1:0]      w_idx, w_ridx;
    logic [TAG_W-1:0]      w_tag, w_rtag;
    logic [WSEL_W-1:0]     w_wsel, w_rwsel;
    logic                  w_busy_int, w_accept, w_beat, w_last;
    logic                  w_hit, w_found;
    logic [WAY_W-1:0]      w_hit_way, w_vict;
    logic [LINE_W-1:0]     w_hit_line, w_new_line;
    logic [DATA_WIDTH-1:0] w_hit_word, w_new_word;
    logic [ADDR_WIDTH-1:0] w_line_addr;
    logic                  w_unused;

    assign w_idx   = req_addr[OFF_W +: IDX_W];
    assign w_tag   = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_wsel  = req_addr[OFF_W-1 : WB_W];
    assign w_ridx  = r_addr[OFF_W +: IDX_W];
    assign w_rtag  = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_rwsel = r_addr[OFF_W-1 : WB_W];
    assign w_unused = ^{bus_resptag, req_addr, r_addr};

    assign w_busy_int = (r_state != S_IDLE) || flush || r_flush_pend;
    assign w_accept   = req_valid && !w_busy_int;
    assign w_beat     = (r_state == S_FILL) && bus_respcyc;
    assign w_last     = w_beat && (r_beat == BEAT_W'(BEATS - 1));
    assign w_line_addr = {r_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && r_tag[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        w_hit_line = r_data[w_hit_way][w_idx];
        w_hit_word = w_hit_line[int'(w_wsel)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lowest invalid way wins; otherwise fall back to the round-robin pointer.
    always_comb begin
        w_vict  = r_ptr[w_idx];
        w_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !r_valid[w_idx][w]) begin
                w_vict  = WAY_W'(w);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_new_line = r_fill;
        w_new_line[int'(r_beat)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
        w_new_word = w_new_line[int'(w_rwsel)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept && !w_hit) w_next = S_REQ;
            S_REQ:   if (bus_reqack) w_next = S_FILL;
            S_FILL:  if (w_last) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = reset && w_busy_int;
        bus_reqcyc  = (r_state == S_REQ);
        bus_req     = bus_reqcyc ? BUS_DATA_WIDTH'(w_line_addr) : '0;
        bus_reqtag  = bus_reqcyc ? READ_TAG : '0;
        bus_respack = w_beat;
        resp_valid  = r_hit_q || (r_state == S_RESP);
        resp_data   = r_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
            r_flush_pend <= 1'b0;
            r_hit_q      <= 1'b0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_vict       <= '0;
            r_beat       <= '0;
            r_fill       <= '0;
        end else begin
            r_hit_q <= 1'b0;
            if (r_state == S_IDLE) begin
                if (flush) begin
                    for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
                end else if (w_accept && w_hit) begin
                    r_hit_q <= 1'b1;
                    r_rdata <= w_hit_word;
                end else if (w_accept) begin
                    r_addr <= req_addr;
                    r_vict <= w_vict;
                end
            end
            if (r_state == S_REQ) r_beat <= '0;
            if (w_beat) begin
                r_fill <= w_new_line;
                r_beat <= r_beat + 1'b1;
            end
            if (w_last) begin
                r_valid[w_ridx][r_vict] <= 1'b1;
                r_rdata <= w_new_word;
                if (r_vict == r_ptr[w_ridx])
                    r_ptr[w_ridx] <= (r_ptr[w_ridx] == WAY_W'(WAYS - 1)) ?
                                     '0 : r_ptr[w_ridx] + 1'b1;
            end
            if (flush && (r_state == S_REQ || r_state == S_FILL))
                r_flush_pend <= 1'b1;
            // Deferred flush lands on the return to idle, killing the new line too.
            if (r_state == S_RESP) begin
                if (flush || r_flush_pend) begin
                    for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
                end
                r_flush_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_last) begin
            r_tag[r_vict][w_ridx]  <= w_rtag;
            r_data[r_vict][w_ridx] <= w_new_line;
        end
    end
endmodule

// File: tb/tb_set_assoc_read_cache.sv
// Bench for set_assoc_read_cache: directed scenarios plus random traffic
// checked cycle by cycle against a tag/valid model and an address-hash memory.
module tb_set_assoc_read_cache;
    localparam logic [12:0] RTAG = 13'h1100;

    typedef struct {
        int          c;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        busy, resp_valid;
    logic [31:0] resp_data;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    logic        bus_respack;

    set_assoc_read_cache dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .flush(flush), .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int n_ack = 0;

    bit          mv [32][4];
    logic [52:0] mt [32][4];
    int          mp [32];

    bit          exp_busy = 0;
    bit          exp_reqcyc = 0;
    bit          exp_fill = 0;
    logic [63:0] exp_line = '0;
    exp_t        expq[$];

    logic [63:0] last_req = '0;
    logic [12:0] last_tag = '0;
    logic [31:0] last_resp = '0;
    int          last_resp_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [63:0] h;
        h = (a >> 13) * 64'd37;
        return a[7:0] ^ h[7:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] b;
        b = a & ~64'h3;
        return {mem_byte(b + 3), mem_byte(b + 2), mem_byte(b + 1), mem_byte(b)};
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] line, input int k);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = mem_byte(line + 64'(8 * k + i));
        return d;
    endfunction

    task automatic model_clear_valid();
        for (int s = 0; s < 32; s++)
            for (int w = 0; w < 4; w++) mv[s][w] = 0;
    endtask

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("reqcyc", 64'(bus_reqcyc), 64'(exp_reqcyc));
        chk("reqtag", 64'(bus_reqtag), exp_reqcyc ? 64'(RTAG) : 64'd0);
        chk("req", bus_req, exp_reqcyc ? exp_line : 64'd0);
        chk("respack", 64'(bus_respack), 64'(bus_respcyc && exp_fill));
        if (bus_reqcyc) begin
            last_req = bus_req;
            last_tag = bus_reqtag;
        end
        if (bus_respack) n_ack++;
        if (expq.size() > 0 && expq[0].c == cyc) begin
            chk("resp_valid", 64'(resp_valid), 64'd1);
            chk("resp_data", 64'(resp_data), 64'(expq[0].d));
            last_resp = resp_data;
            last_resp_cyc = cyc;
            void'(expq.pop_front());
        end else begin
            chk("resp_valid_quiet", 64'(resp_valid), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit respcyc_on);
        exp_busy = 0;
        exp_reqcyc = 0;
        exp_fill = 0;
        expq.delete();
        model_clear_valid();
        for (int s = 0; s < 32; s++) mp[s] = 0;
        #1 reset = 1'b0;
        bus_respcyc = respcyc_on;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("rst_req", bus_req, 64'd0);
        chk("rst_reqtag", 64'(bus_reqtag), 64'd0);
        chk("rst_respack", 64'(bus_respack), 64'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        bus_respcyc = 1'b0;
        tick();
    endtask

    task automatic flush_idle(input logic [63:0] a);
        req_valid = 1'b1;
        req_addr = a;
        flush = 1'b1;
        exp_busy = 1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        exp_busy = 0;
        model_clear_valid();
    endtask

    task automatic access(input logic [63:0] a, input int ackd, input int gap,
                          input int fl_beat, input int rst_beat,
                          output int way, output bit hit);
        int          idx;
        int          c0;
        logic [52:0] tg;
        bit          pend;
        exp_t        e;
        idx = int'(a[10:6]);
        tg = a[63:11];
        hit = 0;
        way = -1;
        pend = 0;
        for (int w = 0; w < 4; w++)
            if (mv[idx][w] && mt[idx][w] == tg) begin
                hit = 1;
                way = w;
            end
        req_valid = 1'b1;
        req_addr = a;
        c0 = cyc;
        tick();
        req_valid = 1'b0;
        if (hit) begin
            e.c = c0 + 1;
            e.d = mem_word(a);
            expq.push_back(e);
            return;
        end
        way = mp[idx];
        for (int w = 3; w >= 0; w--) if (!mv[idx][w]) way = w;
        exp_busy = 1;
        exp_reqcyc = 1;
        exp_line = a & ~64'h3F;
        for (int i = 0; i < ackd; i++) begin
            bus_respcyc = 1'($urandom_range(0, 1));
            tick();
        end
        bus_respcyc = 1'($urandom_range(0, 1));
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        exp_reqcyc = 0;
        exp_fill = 1;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap; g++) begin
                bus_respcyc = 1'b0;
                bus_resp = {$urandom, $urandom};
                tick();
            end
            bus_respcyc = 1'b1;
            bus_resp = beat_data(exp_line, k);
            if (k == fl_beat) begin
                flush = 1'b1;
                pend = 1;
            end
            tick();
            flush = 1'b0;
            bus_respcyc = 1'b0;
            if (k == rst_beat) begin
                apply_reset(1'b1);
                return;
            end
        end
        exp_fill = 0;
        mv[idx][way] = 1;
        mt[idx][way] = tg;
        if (way == mp[idx]) mp[idx] = (mp[idx] + 1) % 4;
        e.c = cyc;
        e.d = mem_word(a);
        expq.push_back(e);
        tick();
        exp_busy = 0;
        if (pend) model_clear_valid();
    endtask

    initial begin
        int          w;
        bit          h;
        int          c_acc;
        int          a0;
        int          r;
        logic [63:0] a;

        @(posedge clk);
        #1;
        apply_reset(1'b0);

        chk("model_word_1000", 64'(mem_word(64'h1000)), 64'h03020100);
        chk("model_word_1004", 64'(mem_word(64'h1004)), 64'h07060504);
        a0 = n_ack;
        c_acc = cyc;
        access(64'h1000, 0, 0, -1, -1, w, h);
        chk("cold_is_miss", 64'(h), 64'd0);
        chk("cold_acks", 64'(n_ack - a0), 64'd8);
        chk("cold_bus_req", last_req, 64'h1000);
        chk("cold_bus_tag", 64'(last_tag), 64'h1100);
        chk("cold_data", 64'(last_resp), 64'h03020100);
        chk("cold_latency", 64'(last_resp_cyc - c_acc), 64'd10);

        access(64'h1004, 0, 0, -1, -1, w, h);
        chk("hit1_is_hit", 64'(h), 64'd1);
        access(64'h103C, 0, 0, -1, -1, w, h);
        chk("hit2_is_hit", 64'(h), 64'd1);
        tick();
        chk("hit2_data", 64'(last_resp), 64'h3F3E3D3C);

        apply_reset(1'b0);
        access(64'h0000, 0, 0, -1, -1, w, h);
        access(64'h0800, 0, 0, -1, -1, w, h);
        access(64'h1000, 0, 0, -1, -1, w, h);
        access(64'h1800, 0, 0, -1, -1, w, h);
        chk("fill4_way", 64'(w), 64'd3);
        access(64'h2000, 0, 0, -1, -1, w, h);
        chk("fill5_evicts_way0", 64'(w), 64'd0);
        access(64'h0800, 0, 0, -1, -1, w, h);
        chk("0800_still_hits", 64'(h), 64'd1);
        access(64'h0000, 0, 0, -1, -1, w, h);
        chk("reread_0000_miss", 64'(h), 64'd0);
        chk("reread_evicts_way1", 64'(w), 64'd1);
        tick();

        flush_idle(64'h1000);
        access(64'h1000, 0, 0, -1, -1, w, h);
        chk("after_flush_miss", 64'(h), 64'd0);

        access(64'h4000, 1, 0, 2, -1, w, h);
        chk("fill_flush_data", 64'(last_resp), 64'(mem_word(64'h4000)));
        access(64'h4000, 0, 0, -1, -1, w, h);
        chk("after_fill_flush_miss", 64'(h), 64'd0);

        access(64'h5000, 5, 2, -1, -1, w, h);
        chk("stall_is_miss", 64'(h), 64'd0);
        chk("stall_data", 64'(last_resp), 64'h49484B4A);

        access(64'h6000, 0, 0, -1, 3, w, h);
        access(64'h6000, 0, 0, -1, -1, w, h);
        chk("after_reset_miss", 64'(h), 64'd0);

        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 15));
            a = (64'($urandom_range(0, 3)) << 13) | (64'($urandom_range(0, 1)) << 11) |
                (64'($urandom_range(0, 1)) << 6) | 64'($urandom_range(0, 63));
            if (r == 0) flush_idle(a);
            else access(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                        (r == 1) ? int'($urandom_range(0, 7)) : -1, -1, w, h);
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
